// File: rtl/fetch_pc_ir_unit_pkg.sv
// Shared types for the LEGv8 fetch unit: PC-select encodings, fetch FSM states, bus widths.
package fetch_pc_ir_unit_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned ADDR_W  = 64;

  typedef enum logic [1:0] {
    PS_HOLD = 2'b00,
    PS_INC  = 2'b01,
    PS_LOAD = 2'b10,
    PS_REL  = 2'b11
  } ps_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    WAIT  = 2'b01,
    FAULT = 2'b10
  } state_e;

endpackage

// File: rtl/fetch_pc_ir_unit_timeout_counter.sv
// Wait-cycle watchdog: counts outstanding-fetch cycles and flags when the limit is reached.
module fetch_timeout_counter #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign expired = (cnt == CNT_W'(TIMEOUT_CYCLES));

endmodule

// File: rtl/fetch_pc_ir_unit.sv
// PC and instruction register for the LEGv8 control unit, with a req/valid fetch
// handshake, timeout watchdog and sticky fault.
module fetch_pc_ir_unit
  import fetch_pc_ir_unit_pkg::*;
#(
  parameter logic [63:0] RESET_PC       = 64'h0,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        il,
  input  logic [1:0]  ps,
  input  logic        pc_sel,
  input  logic [63:0] reg_a,
  input  logic [63:0] constant,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  output logic [31:0] instr,
  output logic [63:0] pc,
  output logic [63:0] pc_instr,
  output logic [63:0] pc_plus4,
  output logic        stall,
  output logic        fetch_fault
);

  state_e              state, state_n;
  logic [ADDR_W-1:0]   pc_n, pc_instr_n, target;
  logic [INSTR_W-1:0]  instr_n;
  logic                accept, cnt_clear, cnt_en, expired;

  fetch_timeout_counter #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_W          (CNT_W)
  ) u_timeout (
    .clock   (clock),
    .reset   (reset),
    .clear   (cnt_clear),
    .enable  (cnt_en),
    .expired (expired)
  );

  // Gating with reset drops the request the instant reset asserts.
  assign imem_req    = reset & il & (state != FAULT);
  assign imem_addr   = pc;
  assign accept      = imem_req & imem_valid;
  assign stall       = reset & ((imem_req & ~imem_valid) | (state == FAULT));
  assign pc_plus4    = pc_instr + 64'd4;
  assign fetch_fault = (state == FAULT);
  assign target      = pc_sel ? constant : reg_a;

  // Next-state and datapath update.
  always_comb begin
    state_n    = state;
    pc_n       = pc;
    pc_instr_n = pc_instr;
    instr_n    = instr;
    cnt_clear  = 1'b0;
    cnt_en     = 1'b0;
    if (accept) begin
      instr_n    = imem_rdata;
      pc_instr_n = pc;
      pc_n       = pc + 64'd4;
      state_n    = IDLE;
      cnt_clear  = 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (il) begin
            state_n = WAIT;
            cnt_en  = 1'b1;
          end else begin
            unique case (ps_e'(ps))
              PS_HOLD: pc_n = pc;
              PS_INC:  pc_n = pc + 64'd4;
              PS_LOAD: begin
                // Misaligned register/absolute targets are unrecoverable.
                if (target[1:0] != 2'b00) state_n = FAULT;
                else                      pc_n    = target;
              end
              PS_REL:  pc_n = pc_instr + {constant[61:0], 2'b00};
              default: pc_n = pc;
            endcase
          end
        end
        WAIT: begin
          if (!il) begin
            state_n   = IDLE;
            cnt_clear = 1'b1;
          end else if (expired) begin
            state_n = FAULT;
          end else begin
            cnt_en = 1'b1;
          end
        end
        FAULT:   state_n = FAULT;
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      pc_instr <= '0;
      instr    <= '0;
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      pc_instr <= pc_instr_n;
      instr    <= instr_n;
    end
  end

endmodule

// File: tb/tb_fetch_pc_ir_unit.sv
// Directed self-checking bench for fetch_pc_ir_unit (instantiated with a 4-cycle timeout).
module tb_fetch_pc_ir_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        il;
  logic [1:0]  ps;
  logic        pc_sel;
  logic [63:0] reg_a;
  logic [63:0] constant;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_valid;
  logic [31:0] instr;
  logic [63:0] pc;
  logic [63:0] pc_instr;
  logic [63:0] pc_plus4;
  logic        stall;
  logic        fetch_fault;

  int checks = 0;
  int errors = 0;

  fetch_pc_ir_unit #(
    .RESET_PC       (64'h0),
    .TIMEOUT_CYCLES (4),
    .CNT_W          (16)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .il          (il),
    .ps          (ps),
    .pc_sel      (pc_sel),
    .reg_a       (reg_a),
    .constant    (constant),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .imem_valid  (imem_valid),
    .instr       (instr),
    .pc          (pc),
    .pc_instr    (pc_instr),
    .pc_plus4    (pc_plus4),
    .stall       (stall),
    .fetch_fault (fetch_fault)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    il = 1'b0; ps = 2'b00; pc_sel = 1'b0; reg_a = '0; constant = '0;
    imem_rdata = '0; imem_valid = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    il = 1'b1;
    imem_valid = 1'b0;
    reset = 1'b0;
    #2;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", imem_req); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", stall); end
    checks++; if (pc !== 64'h0) begin errors++; $display("FAIL reset_pc got %h exp 0", pc); end
    checks++; if (instr !== 32'h0) begin errors++; $display("FAIL reset_instr got %h exp 0", instr); end
    checks++; if (pc_instr !== 64'h0) begin errors++; $display("FAIL reset_pc_instr got %h exp 0", pc_instr); end
    checks++; if (fetch_fault !== 1'b0) begin errors++; $display("FAIL reset_fault got %b exp 0", fetch_fault); end
    tick();
    il = 1'b0;
    reset = 1'b1;
    #1;
  endtask

  task automatic test_zero_wait();
    il = 1'b1; imem_valid = 1'b1; imem_rdata = 32'h8B020020;
    #1;
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL zw_req got %b exp 1", imem_req); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL zw_stall got %b exp 0", stall); end
    checks++; if (imem_addr !== 64'h0) begin errors++; $display("FAIL zw_addr got %h exp 0", imem_addr); end
    tick();
    il = 1'b0; imem_valid = 1'b0;
    #1;
    checks++; if (instr !== 32'h8B020020) begin errors++; $display("FAIL zw_instr got %h exp 8b020020", instr); end
    checks++; if (pc_instr !== 64'h0) begin errors++; $display("FAIL zw_pc_instr got %h exp 0", pc_instr); end
    checks++; if (pc !== 64'h4) begin errors++; $display("FAIL zw_pc got %h exp 4", pc); end
    checks++; if (pc_plus4 !== 64'h4) begin errors++; $display("FAIL zw_pc_plus4 got %h exp 4", pc_plus4); end
  endtask

  task automatic test_wait_fetch();
    il = 1'b1; imem_valid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL wf_stall_c%0d got %b exp 1", c, stall); end
      checks++; if (imem_addr !== 64'h4) begin errors++; $display("FAIL wf_addr_c%0d got %h exp 4", c, imem_addr); end
      tick();
    end
    imem_valid = 1'b1; imem_rdata = 32'h91000421;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL wf_stall_accept got %b exp 0", stall); end
    tick();
    il = 1'b0; imem_valid = 1'b0;
    #1;
    checks++; if (instr !== 32'h91000421) begin errors++; $display("FAIL wf_instr got %h exp 91000421", instr); end
    checks++; if (pc !== 64'h8) begin errors++; $display("FAIL wf_pc got %h exp 8", pc); end
    checks++; if (pc_instr !== 64'h4) begin errors++; $display("FAIL wf_pc_instr got %h exp 4", pc_instr); end
  endtask

  task automatic test_rel_branch();
    ps = 2'b10; pc_sel = 1'b1; constant = 64'h100;
    tick();
    ps = 2'b00;
    #1;
    checks++; if (pc !== 64'h100) begin errors++; $display("FAIL rb_load got %h exp 100", pc); end
    // PS is ignored while IL fetches: pc must advance by exactly 4.
    il = 1'b1; ps = 2'b01; imem_valid = 1'b1; imem_rdata = 32'hB4000040;
    tick();
    il = 1'b0; ps = 2'b11; imem_valid = 1'b0; constant = 64'hFFFF_FFFF_FFFF_FFFE;
    #1;
    checks++; if (pc !== 64'h104) begin errors++; $display("FAIL rb_fetch_pc got %h exp 104", pc); end
    checks++; if (pc_instr !== 64'h100) begin errors++; $display("FAIL rb_pc_instr got %h exp 100", pc_instr); end
    tick();
    ps = 2'b00;
    #1;
    checks++; if (pc !== 64'hF8) begin errors++; $display("FAIL rb_neg got %h exp f8", pc); end
    ps = 2'b10; pc_sel = 1'b1; constant = 64'h104;
    tick();
    ps = 2'b11; constant = 64'h3;
    tick();
    ps = 2'b00;
    #1;
    checks++; if (pc !== 64'h10C) begin errors++; $display("FAIL rb_pos got %h exp 10c", pc); end
  endtask

  task automatic test_reg_branch();
    ps = 2'b10; pc_sel = 1'b0; reg_a = 64'h2000; constant = 64'h0;
    tick();
    #1;
    checks++; if (pc !== 64'h2000) begin errors++; $display("FAIL br_pc got %h exp 2000", pc); end
    checks++; if (fetch_fault !== 1'b0) begin errors++; $display("FAIL br_nofault got %b exp 0", fetch_fault); end
    reg_a = 64'h2002;
    tick();
    ps = 2'b00; il = 1'b1; imem_valid = 1'b1; imem_rdata = 32'hDEADBEEF;
    #1;
    checks++; if (fetch_fault !== 1'b1) begin errors++; $display("FAIL br_fault got %b exp 1", fetch_fault); end
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL br_stall got %b exp 1", stall); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL br_req got %b exp 0", imem_req); end
    checks++; if (pc !== 64'h2000) begin errors++; $display("FAIL br_pc_frozen got %h exp 2000", pc); end
    tick();
    #1;
    checks++; if (instr !== 32'hB4000040) begin errors++; $display("FAIL br_ir_frozen got %h exp b4000040", instr); end
  endtask

  task automatic test_timeout();
    do_reset();
    il = 1'b1; imem_valid = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    checks++; if (fetch_fault !== 1'b0) begin errors++; $display("FAIL to_early got %b exp 0", fetch_fault); end
    tick();
    checks++; if (fetch_fault !== 1'b1) begin errors++; $display("FAIL to_fault got %b exp 1", fetch_fault); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL to_req got %b exp 0", imem_req); end
    imem_valid = 1'b1; imem_rdata = 32'h12345678;
    tick(); tick();
    checks++; if (fetch_fault !== 1'b1 || stall !== 1'b1) begin errors++; $display("FAIL to_sticky got fault=%b stall=%b exp 1/1", fetch_fault, stall); end
    checks++; if (pc !== 64'h0 || instr !== 32'h0) begin errors++; $display("FAIL to_frozen got pc=%h ir=%h exp 0/0", pc, instr); end
    do_reset();
    il = 1'b1; imem_valid = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    imem_valid = 1'b1; imem_rdata = 32'hCAFEF00D;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL to_late_stall got %b exp 0", stall); end
    tick();
    il = 1'b0; imem_valid = 1'b0;
    #1;
    checks++; if (fetch_fault !== 1'b0) begin errors++; $display("FAIL to_late_fault got %b exp 0", fetch_fault); end
    checks++; if (instr !== 32'hCAFEF00D || pc !== 64'h4) begin errors++; $display("FAIL to_late_accept got ir=%h pc=%h exp cafef00d/4", instr, pc); end
  endtask

  task automatic test_wrap_reset();
    do_reset();
    ps = 2'b10; pc_sel = 1'b1; constant = 64'hFFFF_FFFF_FFFF_FFFC;
    tick();
    ps = 2'b00; il = 1'b1; imem_valid = 1'b1; imem_rdata = 32'h00000001;
    tick();
    il = 1'b0; imem_valid = 1'b0;
    #1;
    checks++; if (pc !== 64'h0) begin errors++; $display("FAIL wr_pc got %h exp 0", pc); end
    checks++; if (pc_plus4 !== 64'h0) begin errors++; $display("FAIL wr_plus4 got %h exp 0", pc_plus4); end
    checks++; if (fetch_fault !== 1'b0) begin errors++; $display("FAIL wr_fault got %b exp 0", fetch_fault); end
    il = 1'b1; imem_valid = 1'b1; imem_rdata = 32'h00000002;
    tick();
    imem_valid = 1'b0;
    tick(); tick();
    checks++; if (imem_req !== 1'b1 || pc !== 64'h4) begin errors++; $display("FAIL wr_waiting got req=%b pc=%h exp 1/4", imem_req, pc); end
    reset = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL wr_rst_req got %b exp 0", imem_req); end
    checks++; if (pc !== 64'h0) begin errors++; $display("FAIL wr_rst_pc got %h exp 0", pc); end
    imem_valid = 1'b1; imem_rdata = 32'hBADBAD00;
    tick();
    il = 1'b0; imem_valid = 1'b0;
    reset = 1'b1;
    tick();
    checks++; if (instr !== 32'h0) begin errors++; $display("FAIL wr_late_valid got %h exp 0", instr); end
  endtask

  initial begin
    idle_inputs();
    reset = 1'b0;
    #1;
    test_reset();
    test_zero_wait();
    test_wait_fetch();
    test_rel_branch();
    test_reg_branch();
    test_timeout();
    test_wrap_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
